// File: rtl/parity_frame_serializer.sv
// Parity frame serializer: accepts a parallel word, shifts it out MSB-first,
// then appends an even/odd parity bit so the downstream checker always passes.
module parity_frame_serializer #(
  parameter int DATA_W = 8,
  parameter int GAP    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              mode_in,
  output logic              data_out,
  output logic              valid,
  output logic              mode,
  output logic              frame_last,
  output logic              busy,
  output logic [3:0]        bit_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_GAP} state_t;

  localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);
  localparam logic [3:0] PAR_IDX   = 4'(DATA_W);
  localparam logic [3:0] GAP_LD    = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic              par;
  logic [3:0]        gap_cnt;
  logic              accept;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_SHIFT;
      S_SHIFT:  if (bit_cnt == LAST_DATA) state_nxt = S_PARITY;
      S_PARITY: begin
        if (accept)       state_nxt = S_SHIFT;
        else if (GAP > 0) state_nxt = S_GAP;
        else              state_nxt = S_IDLE;
      end
      S_GAP:    if (gap_cnt == 4'd0) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // With no gap a new word may ride in on the parity cycle for bubble-free frames.
  always_comb begin
    din_ready = !reset && ((state == S_IDLE) || ((state == S_PARITY) && (GAP == 0)));
    accept    = din_valid && din_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg      <= '0;
      par        <= 1'b0;
      data_out   <= 1'b0;
      valid      <= 1'b0;
      mode       <= 1'b0;
      frame_last <= 1'b0;
      busy       <= 1'b0;
      bit_cnt    <= 4'd0;
      gap_cnt    <= 4'd0;
    end else begin
      busy <= (state_nxt != S_IDLE);
      if (accept) begin
        // MSB goes out immediately; shreg holds the remaining bits left-aligned.
        shreg      <= {din[DATA_W-2:0], 1'b0};
        par        <= ^din ^ mode_in;
        data_out   <= din[DATA_W-1];
        valid      <= 1'b1;
        frame_last <= 1'b0;
        bit_cnt    <= 4'd0;
        mode       <= mode_in;
      end else begin
        case (state)
          S_SHIFT: begin
            if (bit_cnt == LAST_DATA) begin
              data_out   <= par;
              frame_last <= 1'b1;
              bit_cnt    <= PAR_IDX;
            end else begin
              data_out <= shreg[DATA_W-1];
              shreg    <= shreg << 1;
              bit_cnt  <= bit_cnt + 4'd1;
            end
          end
          S_PARITY: begin
            valid      <= 1'b0;
            frame_last <= 1'b0;
            bit_cnt    <= 4'd0;
            gap_cnt    <= GAP_LD;
          end
          S_GAP: if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
          default: ;
        endcase
      end
    end
  end

endmodule
